// File: rtl/screen_pkg.sv
// Shared definitions for the OLED screen controller: screen encodings,
// display geometry and RGB565 colour constants.
package screen_pkg;

  typedef enum logic [1:0] {
    HOME     = 2'd0,
    CONTROLS = 2'd1,
    PLAY     = 2'd2,
    OVER     = 2'd3
  } screen_t;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;

  localparam logic [15:0] WHITE  = 16'hFFFF;
  localparam logic [15:0] BLACK  = 16'h0000;
  localparam logic [15:0] RED    = 16'hF800;
  localparam logic [15:0] GREEN  = 16'h07E0;
  localparam logic [15:0] BLUE   = 16'h001F;
  localparam logic [15:0] YELLOW = 16'hFFE0;

  // Screen reached by the centre button from HOME, given the cursor position.
  function automatic screen_t home_target(input logic item);
    return item ? CONTROLS : PLAY;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, stable-level debounce counter and a
// one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 62500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_r;
  logic          sync2_r;
  logic          level_r;
  logic          armed_r;
  logic          pulse_r;
  logic [1:0]    settle_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  assign accept_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);
  assign pulse    = pulse_r;

  // Synchronize, debounce and edge-detect; a button held through reset stays
  // disarmed until it has been seen released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r  <= 1'b0;
      sync2_r  <= 1'b0;
      level_r  <= 1'b0;
      armed_r  <= 1'b0;
      pulse_r  <= 1'b0;
      settle_r <= 2'b00;
      cnt_r    <= '0;
    end else begin
      sync1_r  <= btn;
      sync2_r  <= sync1_r;
      settle_r <= {settle_r[0], 1'b1};
      armed_r  <= armed_r | (settle_r[1] & ~sync2_r);
      pulse_r  <= accept_s & sync2_r & armed_r;
      if (sync2_r != level_r) begin
        if (accept_s) begin
          level_r <= sync2_r;
          cnt_r   <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Top-level OLED screen controller: button events, HOME/CONTROLS/PLAY/OVER
// sequencing with frame-aligned commits, blink phase and pixel source mux.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 62500,
  parameter int BLINK_FRAMES    = 15,
  parameter int OVER_FRAMES     = 180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_c,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        frame_begin,
  input  logic        game_over,
  input  logic [15:0] home_data,
  input  logic [15:0] ctrl_data,
  input  logic [15:0] play_data,
  input  logic [15:0] over_data,
  output logic [1:0]  screen,
  output logic        menu_item,
  output logic        blink_on,
  output logic        game_start,
  output logic [15:0] oled_data
);

  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam int OW = $clog2(OVER_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [OW-1:0] OVER_LAST  = OW'(OVER_FRAMES);

  screen_t       screen_r;
  screen_t       pend_screen_r;
  screen_t       req_screen_s;
  logic          pend_valid_r;
  logic          menu_item_r;
  logic          blink_on_r;
  logic          game_start_r;
  logic [BW-1:0] blink_cnt_r;
  logic [OW-1:0] over_cnt_r;
  logic [15:0]   oled_data_r;
  logic [15:0]   pixel_s;
  logic          ev_c_s;
  logic          ev_u_s;
  logic          ev_d_s;
  logic          req_valid_s;
  logic          toggle_s;
  logic          commit_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
    .clk(clk), .rst_n(rst_n), .btn(btn_c), .pulse(ev_c_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_u (
    .clk(clk), .rst_n(rst_n), .btn(btn_u), .pulse(ev_u_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk(clk), .rst_n(rst_n), .btn(btn_d), .pulse(ev_d_s)
  );

  assign commit_s   = frame_begin & pend_valid_r;
  assign screen     = screen_r;
  assign menu_item  = menu_item_r;
  assign blink_on   = blink_on_r;
  assign game_start = game_start_r;
  assign oled_data  = oled_data_r;

  // Decode events into a screen request or a cursor toggle; C outranks U/D,
  // and nothing is accepted while a request waits for its frame boundary.
  always_comb begin
    req_valid_s  = 1'b0;
    req_screen_s = HOME;
    toggle_s     = 1'b0;
    if (pend_valid_r) begin
      req_valid_s = 1'b0;
    end else begin
      case (screen_r)
        HOME: begin
          if (ev_c_s) begin
            req_valid_s  = 1'b1;
            req_screen_s = home_target(menu_item_r);
          end else begin
            toggle_s = ev_u_s | ev_d_s;
          end
        end
        CONTROLS: req_valid_s = ev_c_s;
        PLAY: begin
          req_valid_s  = game_over;
          req_screen_s = OVER;
        end
        OVER:    req_valid_s = ev_c_s | (over_cnt_r == OVER_LAST);
        default: req_valid_s = 1'b0;
      endcase
    end
  end

  // Select the renderer belonging to the currently committed screen.
  always_comb begin
    pixel_s = 16'h0000;
    case (screen_r)
      HOME:     pixel_s = home_data;
      CONTROLS: pixel_s = ctrl_data;
      PLAY:     pixel_s = play_data;
      OVER:     pixel_s = over_data;
      default:  pixel_s = 16'h0000;
    endcase
  end

  // Screen state, pending request, cursor, blink and OVER timers, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      screen_r      <= HOME;
      pend_screen_r <= HOME;
      pend_valid_r  <= 1'b0;
      menu_item_r   <= 1'b0;
      blink_on_r    <= 1'b1;
      blink_cnt_r   <= '0;
      over_cnt_r    <= '0;
      game_start_r  <= 1'b0;
      oled_data_r   <= 16'h0000;
    end else begin
      oled_data_r  <= pixel_s;
      game_start_r <= 1'b0;
      if (commit_s) begin
        screen_r     <= pend_screen_r;
        pend_valid_r <= 1'b0;
        blink_cnt_r  <= '0;
        blink_on_r   <= 1'b1;
        over_cnt_r   <= '0;
        game_start_r <= (pend_screen_r == PLAY);
      end else begin
        if (req_valid_s) begin
          pend_valid_r  <= 1'b1;
          pend_screen_r <= req_screen_s;
        end
        if (toggle_s) begin
          menu_item_r <= ~menu_item_r;
        end
        if (frame_begin) begin
          if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r <= '0;
            blink_on_r  <= ~blink_on_r;
          end else begin
            blink_cnt_r <= blink_cnt_r + BW'(1);
          end
          if ((screen_r == OVER) && (over_cnt_r != OVER_LAST)) begin
            over_cnt_r <= over_cnt_r + OW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_screen_sequencer.sv
// Self-checking bench for screen_sequencer: a per-cycle reference model
// compared every cycle, a table of navigation vectors and timing sequences.
module tb_screen_sequencer;

  localparam int D  = 4;
  localparam int BF = 15;
  localparam int OF = 180;
  localparam int FP = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_c = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic        frame_begin = 1'b0, game_over = 1'b0;
  logic [15:0] home_data = 16'h0, ctrl_data = 16'h0, play_data = 16'h0, over_data = 16'h0;
  logic [1:0]  screen;
  logic        menu_item, blink_on, game_start;
  logic [15:0] oled_data;

  int n_cmp = 0;
  int n_bad = 0;
  int fcnt  = 0;

  screen_sequencer #(.DEBOUNCE_CYCLES(D), .BLINK_FRAMES(BF), .OVER_FRAMES(OF)) dut (
    .clk(clk), .rst_n(rst_n), .btn_c(btn_c), .btn_u(btn_u), .btn_d(btn_d),
    .frame_begin(frame_begin), .game_over(game_over),
    .home_data(home_data), .ctrl_data(ctrl_data), .play_data(play_data), .over_data(over_data),
    .screen(screen), .menu_item(menu_item), .blink_on(blink_on),
    .game_start(game_start), .oled_data(oled_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame pulse every FP cycles and fresh random renderer pixels each cycle.
  always @(negedge clk) begin
    fcnt = (fcnt == FP - 1) ? 0 : fcnt + 1;
    frame_begin = (fcnt == 0);
    home_data = 16'($urandom);
    ctrl_data = 16'($urandom);
    play_data = 16'($urandom);
    over_data = 16'($urandom);
  end

  // Reference model: screens as 0..3; a button press is accepted once its
  // 2-cycle delayed level has held the new value for D samples in a row.
  int          m_screen, m_pscr, m_bcnt, m_ocnt, n_edges;
  bit          m_pend, m_menu, m_blink, m_gs;
  logic [15:0] m_oled;
  logic [7:0]  hist [3];
  bit          lvl [3];
  bit          armed [3];
  bit          ev [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_screen = 0; m_pscr = 0; m_bcnt = 0; m_ocnt = 0; n_edges = 0;
      m_pend = 0; m_menu = 0; m_blink = 1; m_gs = 0; m_oled = 16'h0000;
      for (int b = 0; b < 3; b++) begin
        hist[b] = 8'h00; lvl[b] = 0; armed[b] = 0; ev[b] = 0;
      end
    end else begin
      bit c, u, dn, flip;
      logic [2:0]   raw;
      logic [D-1:0] win;
      case (m_screen)
        0:       m_oled = home_data;
        1:       m_oled = ctrl_data;
        2:       m_oled = play_data;
        default: m_oled = over_data;
      endcase
      m_gs = 0;
      c  = ev[0];
      u  = ev[1] && !c;
      dn = ev[2] && !c && !ev[1];
      if (frame_begin && m_pend) begin
        m_screen = m_pscr; m_pend = 0; m_bcnt = 0; m_blink = 1; m_ocnt = 0;
        m_gs = (m_pscr == 2);
      end else begin
        if (!m_pend) begin
          if (m_screen == 0) begin
            if (c) begin m_pend = 1; m_pscr = m_menu ? 1 : 2; end
            else if (u || dn) m_menu = !m_menu;
          end else if (m_screen == 1) begin
            if (c) begin m_pend = 1; m_pscr = 0; end
          end else if (m_screen == 2) begin
            if (game_over) begin m_pend = 1; m_pscr = 3; end
          end else if (c || m_ocnt >= OF) begin
            m_pend = 1; m_pscr = 0;
          end
        end
        if (frame_begin) begin
          m_bcnt++;
          if (m_bcnt == BF) begin m_bcnt = 0; m_blink = !m_blink; end
          if (m_screen == 3 && m_ocnt < OF) m_ocnt++;
        end
      end
      n_edges++;
      raw = {btn_d, btn_u, btn_c};
      for (int b = 0; b < 3; b++) begin
        win  = hist[b][D:1];
        flip = lvl[b] ? (win == '0) : (win == '1);
        ev[b] = 0;
        if (flip) begin
          lvl[b] = !lvl[b];
          ev[b]  = lvl[b] && armed[b];
        end
        if (n_edges >= 3 && hist[b][1] == 1'b0) armed[b] = 1;
        hist[b] = {hist[b][6:0], raw[b]};
      end
    end
  end

  // Every cycle, away from the clock edge, compare all outputs with the model.
  always @(negedge clk) begin
    #1;
    check("screen",     int'(screen),     m_screen);
    check("menu_item",  int'(menu_item),  int'(m_menu));
    check("blink_on",   int'(blink_on),   int'(m_blink));
    check("game_start", int'(game_start), int'(m_gs));
    check("oled_data",  int'(oled_data),  int'(m_oled));
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Advance to just past the next frame_begin edge.
  task automatic wait_fb();
    int k = 0;
    while (!frame_begin && k < 2 * FP) begin
      step();
      k++;
    end
    check("frame_begin_seen", int'(frame_begin), 1);
    step();
  endtask

  task automatic press(input bit c, input bit u, input bit d, input bit go, input int hold);
    btn_c = c; btn_u = u; btn_d = d; game_over = go;
    repeat (hold) step();
    btn_c = 1'b0; btn_u = 1'b0; btn_d = 1'b0; game_over = 1'b0;
  endtask

  task automatic do_cmd(input bit c, input bit u, input bit d, input bit go);
    wait_fb();
    press(c, u, d, go, 10);
    wait_fb();
  endtask

  typedef struct {
    bit c, u, d, go;
    int hold;
    int exp_scr;
    bit exp_menu;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int k;
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 0, 1'b1};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 10, 2, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 2, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 2, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1,  3, 3, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 10, 0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0,  3, 0, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 1, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 10, 1, 1'b1};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 10, 0, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 10, 0, 1'b0};

    step();
    check("rst_screen",     int'(screen),     0);
    check("rst_menu_item",  int'(menu_item),  0);
    check("rst_blink_on",   int'(blink_on),   1);
    check("rst_game_start", int'(game_start), 0);
    check("rst_oled_data",  int'(oled_data),  0);
    step();
    rst_n = 1'b1;
    repeat (5) step();

    for (int i = 0; i < 15; i++) begin
      wait_fb();
      press(tbl[i].c, tbl[i].u, tbl[i].d, tbl[i].go, tbl[i].hold);
      wait_fb();
      check($sformatf("tbl%0d_screen", i), int'(screen), tbl[i].exp_scr);
      check($sformatf("tbl%0d_menu", i), int'(menu_item), int'(tbl[i].exp_menu));
    end

    // Event latency: menu_item flips on the 7th edge after the raw press.
    wait_fb();
    btn_d = 1'b1;
    repeat (6) step();
    check("d_latency_edge6", int'(menu_item), 0);
    step();
    check("d_latency_edge7", int'(menu_item), 1);
    repeat (3) step();
    btn_d = 1'b0;
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("menu_back_to_0", int'(menu_item), 0);

    // Commit lands exactly on frame_begin with a single game_start pulse.
    wait_fb();
    press(1'b1, 1'b0, 1'b0, 1'b0, 10);
    k = 0;
    while (!frame_begin && k < 2 * FP) begin step(); k++; end
    check("pre_commit_screen", int'(screen), 0);
    check("pre_commit_gs", int'(game_start), 0);
    step();
    check("commit_screen_play", int'(screen), 2);
    check("commit_gs_pulse", int'(game_start), 1);
    step();
    check("gs_single_cycle", int'(game_start), 0);
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    do_cmd(1'b0, 1'b1, 1'b0, 1'b0);
    check("play_ignores_buttons", int'(screen), 2);
    wait_fb();
    game_over = 1'b1;
    wait_fb();
    game_over = 1'b0;
    check("game_over_to_over", int'(screen), 3);

    // OVER auto-return: counter reaches OF at frame OF, commit one frame later.
    for (int f = 1; f <= OF + 1; f++) begin
      wait_fb();
      if (f == OF) check("over_held_f180", int'(screen), 3);
    end
    check("over_timeout_home", int'(screen), 0);

    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    wait_fb();
    game_over = 1'b1;
    wait_fb();
    game_over = 1'b0;
    for (int f = 1; f <= 50; f++) wait_fb();
    check("over_at_f50", int'(screen), 3);
    press(1'b1, 1'b0, 1'b0, 1'b0, 10);
    wait_fb();
    check("over_btn_c_f51", int'(screen), 0);

    // Blink phase: toggles on every 15th frame after a commit.
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    for (int f = 1; f <= 2 * BF; f++) begin
      wait_fb();
      if (f == BF - 1)     check("blink_f14", int'(blink_on), 1);
      if (f == BF)         check("blink_f15", int'(blink_on), 0);
      if (f == 2 * BF - 1) check("blink_f29", int'(blink_on), 0);
      if (f == 2 * BF)     check("blink_f30", int'(blink_on), 1);
    end

    // Reset while a request is pending clears it.
    wait_fb();
    game_over = 1'b1;
    step();
    step();
    game_over = 1'b0;
    rst_n = 1'b0;
    step();
    check("rst_pending_screen", int'(screen), 0);
    rst_n = 1'b1;
    wait_fb();
    check("no_commit_after_rst", int'(screen), 0);

    // A button held through reset release produces no event until re-pressed.
    btn_c = 1'b1;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    repeat (20) step();
    wait_fb();
    check("held_through_rst", int'(screen), 0);
    btn_c = 1'b0;
    repeat (10) step();
    do_cmd(1'b1, 1'b0, 1'b0, 1'b0);
    check("rearm_after_release", int'(screen), 2);

    // Random buttons and game_over against the model.
    for (int i = 0; i < 4000; i++) begin
      step();
      if ($urandom_range(11) == 0) btn_c = ~btn_c;
      if ($urandom_range(11) == 0) btn_u = ~btn_u;
      if ($urandom_range(11) == 0) btn_d = ~btn_d;
      if ($urandom_range(49) == 0) game_over = ~game_over;
    end
    btn_c = 1'b0; btn_u = 1'b0; btn_d = 1'b0; game_over = 1'b0;
    repeat (50) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
